// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle processor control unit: state codes,
// primary opcodes, mux/ALU select codes and the bundled control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EXA  = 4'd2,
    S_MRD  = 4'd3,
    S_MWR  = 4'd4,
    S_WBM  = 4'd5,
    S_EXR  = 4'd6,
    S_EXI  = 4'd7,
    S_WBA  = 4'd8,
    S_BEQ  = 4'd9,
    S_JMP  = 4'd10,
    S_HALT = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       iorD;
    logic       regDst;
    logic       memtoReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic [1:0] aluOp;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decode: turns the current state (plus the memory handshake,
// ALU zero flag and latched destination select) into the control word.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e State,
  input  logic   MemReady,
  input  logic   Zero,
  input  logic   RegDstLatch,
  output ctrl_t  Ctrl
);

  // Everything not named for a state stays zero, including illegal codes.
  always_comb begin
    Ctrl = '0;
    case (State)
      S_IF: begin
        Ctrl.memRead = 1'b1;
        Ctrl.aluSrcB = ALUSRCB_FOUR;
        Ctrl.aluOp   = ALUOP_ADD;
        Ctrl.pcSrc   = PCSRC_ALU;
        Ctrl.pcWrite = MemReady;
        Ctrl.irWrite = MemReady;
      end
      S_ID: begin
        Ctrl.aluSrcB = ALUSRCB_IMMSH;
        Ctrl.aluOp   = ALUOP_ADD;
      end
      S_EXA: begin
        Ctrl.aluSrcA = 1'b1;
        Ctrl.aluSrcB = ALUSRCB_IMM;
        Ctrl.aluOp   = ALUOP_ADD;
      end
      S_MRD: begin
        Ctrl.memRead = 1'b1;
        Ctrl.iorD    = 1'b1;
      end
      S_MWR: begin
        Ctrl.memWrite = 1'b1;
        Ctrl.iorD     = 1'b1;
      end
      S_WBM: begin
        Ctrl.regWrite = 1'b1;
        Ctrl.memtoReg = 1'b1;
      end
      S_EXR: begin
        Ctrl.aluSrcA = 1'b1;
        Ctrl.aluSrcB = ALUSRCB_REG;
        Ctrl.aluOp   = ALUOP_FUNC;
      end
      S_EXI: begin
        Ctrl.aluSrcA = 1'b1;
        Ctrl.aluSrcB = ALUSRCB_IMM;
        Ctrl.aluOp   = ALUOP_ADD;
      end
      S_WBA: begin
        Ctrl.regWrite = 1'b1;
        Ctrl.regDst   = RegDstLatch;
      end
      S_BEQ: begin
        Ctrl.aluSrcA = 1'b1;
        Ctrl.aluSrcB = ALUSRCB_REG;
        Ctrl.aluOp   = ALUOP_SUB;
        Ctrl.pcSrc   = PCSRC_ALUOUT;
        Ctrl.pcWrite = Zero;
      end
      S_JMP: begin
        Ctrl.pcSrc   = PCSRC_JUMP;
        Ctrl.pcWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control FSM: holds the state and the RegDst latch,
// sequences instructions and gates all decoded outputs while in reset.
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUOp,
  output logic [3:0] State,
  output logic       IllegalOp
);

  state_e state_q, state_d;
  logic   regDst_q, regDst_d;
  logic   illegalId;
  ctrl_t  decCtrl;
  ctrl_t  ctrl;

  always_comb begin
    state_d   = S_IF;
    regDst_d  = regDst_q;
    illegalId = 1'b0;
    case (state_q)
      S_IF:  state_d = MemReady ? S_ID : S_IF;
      S_ID: begin
        if (Opcode == OP_LW || Opcode == OP_SW) state_d = S_EXA;
        else if (Opcode == OP_R)                state_d = S_EXR;
        else if (Opcode == OP_ADDI)             state_d = S_EXI;
        else if (Opcode == OP_BEQ)              state_d = S_BEQ;
        else if (Opcode == OP_J)                state_d = S_JMP;
        else if (Opcode == HALT_OP)             state_d = S_HALT;
        else begin
          state_d   = S_IF;
          illegalId = 1'b1;
        end
      end
      S_EXA: begin
        if (Opcode == OP_LW)      state_d = S_MRD;
        else if (Opcode == OP_SW) state_d = S_MWR;
        else                      state_d = S_IF;
      end
      S_MRD: state_d = MemReady ? S_WBM : S_MRD;
      S_MWR: state_d = MemReady ? S_IF : S_MWR;
      S_WBM: state_d = S_IF;
      S_EXR: begin
        state_d  = S_WBA;
        regDst_d = 1'b1;
      end
      S_EXI: begin
        state_d  = S_WBA;
        regDst_d = 1'b0;
      end
      S_WBA:  state_d = S_IF;
      S_BEQ:  state_d = S_IF;
      S_JMP:  state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IF;
      regDst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      regDst_q <= regDst_d;
    end
  end

  mc_ctrl_outdec uOutDec (
    .State      (state_q),
    .MemReady   (MemReady),
    .Zero       (Zero),
    .RegDstLatch(regDst_q),
    .Ctrl       (decCtrl)
  );

  // IF decodes strobes from MemReady alone, so reset must mask the word here.
  assign ctrl      = Rst_n ? decCtrl : '0;
  assign IllegalOp = Rst_n & illegalId;
  assign State     = state_q;

  assign PCWrite  = ctrl.pcWrite;
  assign IRWrite  = ctrl.irWrite;
  assign MemRead  = ctrl.memRead;
  assign MemWrite = ctrl.memWrite;
  assign RegWrite = ctrl.regWrite;
  assign IorD     = ctrl.iorD;
  assign RegDst   = ctrl.regDst;
  assign MemtoReg = ctrl.memtoReg;
  assign ALUSrcA  = ctrl.aluSrcA;
  assign ALUSrcB  = ctrl.aluSrcB;
  assign PCSrc    = ctrl.pcSrc;
  assign ALUOp    = ctrl.aluOp;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: each stimulus cycle queues its
// expected state/control word, a negedge monitor pops and compares.
module tb_multi_cycle_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [5:0] Opcode = 6'b0;
  logic       MemReady = 1'b1;
  logic       Zero = 1'b0;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
  logic       IorD, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc, ALUOp;
  logic [3:0] State;
  logic       IllegalOp;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] outs;
    string       name;
  } exp_t;

  exp_t expQ[$];

  multi_cycle_ctrl #(.HALT_OP(6'b111111)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Opcode(Opcode), .MemReady(MemReady), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .State(State), .IllegalOp(IllegalOp)
  );

  always #5 Clk = ~Clk;

  // Observed control word, same bit order as expOut builds it.
  wire [15:0] actOut = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IorD, RegDst,
                        MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUOp, IllegalOp};

  // Control table written straight from the state descriptions (IllegalOp added separately).
  function automatic logic [15:0] expOut(input logic [3:0] st, input logic mr,
                                         input logic z, input logic rd);
    logic pcw, irw, mrd, mwr, rgw, iod, rdst, m2r, asa;
    logic [1:0] asb, pcs, aop;
    {pcw, irw, mrd, mwr, rgw, iod, rdst, m2r, asa} = '0;
    {asb, pcs, aop} = '0;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin mwr = 1; iod = 1; end
      4'd5:  begin rgw = 1; m2r = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin asa = 1; asb = 2'b10; end
      4'd8:  begin rgw = 1; rdst = rd; end
      4'd9:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pcw = z; end
      4'd10: begin pcs = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, irw, mrd, mwr, rgw, iod, rdst, m2r, asa, asb, pcs, aop, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; expectation describes the cycle just entered.
  task automatic applyStimulus(input logic rstN, input logic [5:0] op, input logic mr,
                               input logic z, input logic [3:0] expState,
                               input logic expRd, input logic expIll, input string name);
    exp_t e;
    @(posedge Clk);
    #1;
    Rst_n    = rstN;
    Opcode   = op;
    MemReady = mr;
    Zero     = z;
    e.st   = rstN ? expState : 4'd0;
    e.outs = rstN ? (expOut(expState, mr, z, expRd) | {15'b0, expIll}) : 16'h0000;
    e.name = name;
    expQ.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput({e.name, "/state"}, {12'b0, State}, {12'b0, e.st});
        checkOutput({e.name, "/ctrl"}, actOut, e.outs);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Reset held with MemReady=1: IF strobes must be masked.
    applyStimulus(0, 6'b000000, 1, 0, 0, 0, 0, "reset");

    // R-type: 0,1,6,8,0 with RegDst=1 only in WBA.
    applyStimulus(1, 6'b000000, 1, 0, 0, 0, 0, "r_if");
    applyStimulus(1, 6'b000000, 1, 0, 1, 0, 0, "r_id");
    applyStimulus(1, 6'b000000, 1, 0, 6, 0, 0, "r_exr");
    applyStimulus(1, 6'b000000, 1, 0, 8, 1, 0, "r_wba");

    // Fetch wait, then addi writes back with RegDst=0.
    applyStimulus(1, 6'b001000, 0, 0, 0, 0, 0, "addi_ifwait");
    applyStimulus(1, 6'b001000, 1, 0, 0, 0, 0, "addi_if");
    applyStimulus(1, 6'b001000, 1, 0, 1, 0, 0, "addi_id");
    applyStimulus(1, 6'b001000, 1, 0, 7, 0, 0, "addi_exi");
    applyStimulus(1, 6'b001000, 1, 0, 8, 0, 0, "addi_wba");

    // lw with two MRD wait cycles: 0,1,2,3,3,3,5.
    applyStimulus(1, 6'b100011, 1, 0, 0, 0, 0, "lw_if");
    applyStimulus(1, 6'b100011, 1, 0, 1, 0, 0, "lw_id");
    applyStimulus(1, 6'b100011, 1, 0, 2, 0, 0, "lw_exa");
    applyStimulus(1, 6'b100011, 0, 0, 3, 0, 0, "lw_mrd0");
    applyStimulus(1, 6'b100011, 0, 0, 3, 0, 0, "lw_mrd1");
    applyStimulus(1, 6'b100011, 1, 0, 3, 0, 0, "lw_mrd2");
    applyStimulus(1, 6'b100011, 1, 0, 5, 0, 0, "lw_wbm");

    // sw with one MWR wait, completes back to IF.
    applyStimulus(1, 6'b101011, 1, 0, 0, 0, 0, "sw_if");
    applyStimulus(1, 6'b101011, 1, 0, 1, 0, 0, "sw_id");
    applyStimulus(1, 6'b101011, 1, 0, 2, 0, 0, "sw_exa");
    applyStimulus(1, 6'b101011, 0, 0, 4, 0, 0, "sw_mwr0");
    applyStimulus(1, 6'b101011, 1, 0, 4, 0, 0, "sw_mwr1");

    // beq taken then not taken.
    applyStimulus(1, 6'b000100, 1, 1, 0, 0, 0, "beqt_if");
    applyStimulus(1, 6'b000100, 1, 1, 1, 0, 0, "beqt_id");
    applyStimulus(1, 6'b000100, 1, 1, 9, 0, 0, "beqt_beq");
    applyStimulus(1, 6'b000100, 1, 0, 0, 0, 0, "beqn_if");
    applyStimulus(1, 6'b000100, 1, 0, 1, 0, 0, "beqn_id");
    applyStimulus(1, 6'b000100, 1, 0, 9, 0, 0, "beqn_beq");

    // Jump.
    applyStimulus(1, 6'b000010, 1, 0, 0, 0, 0, "j_if");
    applyStimulus(1, 6'b000010, 1, 0, 1, 0, 0, "j_id");
    applyStimulus(1, 6'b000010, 1, 0, 10, 0, 0, "j_jmp");

    // Illegal opcode pulses IllegalOp only in ID, then refetches.
    applyStimulus(1, 6'b010101, 1, 0, 0, 0, 0, "ill_if");
    applyStimulus(1, 6'b010101, 1, 0, 1, 0, 1, "ill_id");
    applyStimulus(1, 6'b000000, 0, 0, 0, 0, 0, "ill_after");

    // sw aborted by reset in the middle of an MWR wait.
    applyStimulus(1, 6'b101011, 1, 0, 0, 0, 0, "swa_if");
    applyStimulus(1, 6'b101011, 1, 0, 1, 0, 0, "swa_id");
    applyStimulus(1, 6'b101011, 1, 0, 2, 0, 0, "swa_exa");
    applyStimulus(1, 6'b101011, 0, 0, 4, 0, 0, "swa_mwr0");
    @(posedge Clk);
    #1;
    MemReady = 0;
    #2;
    checkOutput("swa_wait_memwrite", {15'b0, MemWrite}, 16'h0001);
    Rst_n = 0;
    #1;
    checkOutput("swa_async_memwrite", {15'b0, MemWrite}, 16'h0000);
    checkOutput("swa_async_state", {12'b0, State}, 16'h0000);
    checkOutput("swa_async_ctrl", actOut, 16'h0000);
    applyStimulus(0, 6'b101011, 1, 0, 0, 0, 0, "swa_inreset");

    // Release: first fetch, then R-type again with latch restored.
    applyStimulus(1, 6'b000000, 1, 0, 0, 0, 0, "rel_if");
    applyStimulus(1, 6'b000000, 1, 0, 1, 0, 0, "rel_id");
    applyStimulus(1, 6'b000000, 1, 0, 6, 0, 0, "rel_exr");
    applyStimulus(1, 6'b000000, 1, 0, 8, 1, 0, "rel_wba");

    // HALT parks for 20 cycles whatever MemReady/Zero do.
    applyStimulus(1, 6'b111111, 1, 0, 0, 0, 0, "halt_if");
    applyStimulus(1, 6'b111111, 1, 0, 1, 0, 0, "halt_id");
    for (int i = 0; i < 20; i++)
      applyStimulus(1, 6'b111111, i[0], ~i[0], 11, 1, 0, $sformatf("halt_%0d", i));

    // Reset leaves HALT.
    applyStimulus(0, 6'b000000, 1, 0, 0, 0, 0, "halt_reset");
    applyStimulus(1, 6'b000000, 1, 0, 0, 0, 0, "halt_refetch");

    repeat (3) @(negedge Clk);
    #1;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter HALT_OP, default 6'b111111, opcode that parks the FSM in HALT.
REQ-002 SHALL have port Clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port Rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port MemReady  input  1  memory handshake, 1 = current access completes this cycle.
REQ-006 SHALL have port Zero  input  1  ALU zero flag, used only in BEQ.
REQ-007 SHALL have ports PCWrite, IRWrite, MemRead, MemWrite, RegWrite  output  1 each  write/access strobes.
REQ-008 SHALL have ports IorD, RegDst, MemtoReg, ALUSrcA  output  1 each  selects for the 2-input muxes.
REQ-009 SHALL have ports ALUSrcB, PCSrc, ALUOp  output  2 each  selects for the 4-input muxes and the ALU decoder.
REQ-010 SHALL have ports State  output  4  current state; IllegalOp  output  1  one-cycle pulse.

Function
REQ-011 SHALL implement a Moore FSM with states IF=0, ID=1, EXA=2 (lw/sw address), MRD=3, MWR=4, WBM=5, EXR=6 (R-type), EXI=7 (addi), WBA=8, BEQ=9, JMP=10, HALT=11; all outputs SHALL be decoded from State, plus MemReady/Zero where stated.
REQ-012 IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; PCWrite=IRWrite=MemReady; stay in IF while MemReady=0, go to ID when MemReady=1.
REQ-013 ID: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next by Opcode: 100011/101011->EXA, 000000->EXR, 001000->EXI, 000100->BEQ, 000010->JMP, HALT_OP->HALT, other->IF with IllegalOp=1 for that cycle.
REQ-014 EXA: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw->MRD, sw->MWR.
REQ-015 MRD: MemRead=1, IorD=1; hold until MemReady=1, then WBM.
REQ-016 MWR: MemWrite=1, IorD=1; hold until MemReady=1, then IF; MemWrite SHALL stay asserted every waiting cycle.
REQ-017 WBM: RegWrite=1, RegDst=0, MemtoReg=1; ->IF.
REQ-018 EXR: ALUSrcA=1, ALUSrcB=00, ALUOp=10; ->WBA with RegDst=1. EXI: ALUSrcA=1, ALUSrcB=10, ALUOp=00; ->WBA with RegDst=0.
REQ-019 WBA: RegWrite=1, MemtoReg=0, RegDst as latched in a 1-bit register on leaving EXR/EXI; ->IF.
REQ-020 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWrite=Zero; ->IF.
REQ-021 JMP: PCSrc=10, PCWrite=1; ->IF.
REQ-022 HALT: all strobes 0; remain until reset.
REQ-023 Any output not listed for a state SHALL be 0; PCSrc=11 and State codes 12-15 SHALL never occur; an illegal State SHALL recover to IF on the next edge.
REQ-024 Instruction latency: lw 5 cycles, sw/R/addi 4, beq/j 3, each plus one cycle per MemReady=0 wait cycle.

Reset
REQ-025 Rst_n low SHALL immediately force State=IF, the RegDst latch=0, and every strobe 0, including PCWrite/IRWrite regardless of MemReady; selects SHALL be 0 and IllegalOp=0.
REQ-026 Reset asserted mid-instruction, including during a MRD/MWR wait, SHALL abort it with no further strobe; the first fetch SHALL start on the first edge after release.

Structure
REQ-027 A shared package mc_ctrl_pkg SHALL hold the state encodings, opcode constants (R, LW, SW, BEQ, ADDI, J), and the ALUOp/PCSrc/ALUSrcB codes.
REQ-028 Output decode SHALL be a sub-module mc_ctrl_outdec, combinational from State/MemReady/Zero/RegDst latch; the top SHALL hold only the state and latch registers.

Verification
REQ-029 Reset release, MemReady=1, Opcode=000000 -> States 0,1,6,8,0; RegWrite=1 and RegDst=1 only in state 8.
REQ-030 Opcode=100011, MemReady low for 2 cycles in MRD -> States 0,1,2,3,3,3,5,0; IorD=1 for all three MRD cycles.
REQ-031 Opcode=000100: Zero=1 -> PCWrite=1, PCSrc=01 in state 9; Zero=0 -> PCWrite=0.
REQ-032 Opcode=010101 -> IllegalOp pulses 1 cycle in ID, next State=0, no other strobe asserted.
REQ-033 Rst_n driven low during an MWR wait -> MemWrite drops asynchronously, State=0; Opcode=111111 -> State stays 11 for 20 cycles.
